// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell/result codes, winning-line table and FSM state type.
//   CELL_*     2-bit board cell codes
//   WHO_*      2-bit game result codes
//   LINE_TABLE 8 lines, entry l = {idx_a, idx_b, idx_c} (4 bits each)
//   state_t    auto-player FSM states
package ttt_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] WHO_RUN    = 2'b00;
  localparam logic [1:0] WHO_P1     = 2'b01;
  localparam logic [1:0] WHO_P2     = 2'b10;
  localparam logic [1:0] WHO_DRAW   = 2'b11;
  // Line 0 is the rightmost entry: rows, then columns, then diagonals.
  localparam logic [7:0][11:0] LINE_TABLE = {
    12'h246, 12'h048, 12'h258, 12'h147, 12'h036, 12'h678, 12'h345, 12'h012
  };
  typedef enum logic [1:0] {IDLE, THINK, DRIVE, WAIT} state_t;
endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: classifies one three-cell line for the auto player.
//   a, b, c    cell codes of the line
//   ia, ib, ic board indices of those cells
//   win        two player2 marks and one empty cell
//   block      two player1 marks and one empty cell
//   idx        index of the first empty cell of the line
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [3:0] ia,
  input  logic [3:0] ib,
  input  logic [3:0] ic,
  output logic       win,
  output logic       block,
  output logic [3:0] idx
);
  logic [1:0] n_empty, n_p1, n_p2;
  assign n_empty = {1'b0, a == CELL_EMPTY} + {1'b0, b == CELL_EMPTY} + {1'b0, c == CELL_EMPTY};
  assign n_p1    = {1'b0, a == CELL_P1} + {1'b0, b == CELL_P1} + {1'b0, c == CELL_P1};
  assign n_p2    = {1'b0, a == CELL_P2} + {1'b0, b == CELL_P2} + {1'b0, c == CELL_P2};
  assign win     = n_empty == 2'd1 && n_p2 == 2'd2;
  assign block   = n_empty == 2'd1 && n_p1 == 2'd2;
  assign idx     = a == CELL_EMPTY ? ia : b == CELL_EMPTY ? ib : ic;
endmodule

// File: rtl/tic_tac_toe_auto_player.sv
// tic_tac_toe_auto_player: automatic player2 that picks a cell and strobes it into the game.
//   clock, reset (async, active-low), enable, pos1..pos9 (board), who (result)
//   play (move strobe), position (chosen cell), busy (not IDLE), err (ack timeout pulse)
//   TTT_AUTO_STRATEGY_EN: when defined, an 8-cycle line scan picks win > block > centre > lowest
//   empty; otherwise the lowest empty cell is taken after a single THINK cycle.
module tic_tac_toe_auto_player
  import ttt_pkg::*;
#(
  parameter int PLAY_HOLD   = 5,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic       play,
  output logic [3:0] position,
  output logic       busy,
  output logic       err
);
  localparam logic [15:0] PH = 16'(PLAY_HOLD);
  localparam logic [15:0] AT = 16'(ACK_TIMEOUT - 1);
  state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [17:0] board;
  logic [3:0]  n1, n2, low, choice, position_d;
  logic        has_empty, turn, last, ok, ack, play_d, err_d;
  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  always_comb begin
    n1 = 4'd0;
    n2 = 4'd0;
    low = 4'd0;
    has_empty = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      n1 = n1 + {3'd0, board[2*i +: 2] == CELL_P1};
      n2 = n2 + {3'd0, board[2*i +: 2] == CELL_P2};
      if (board[2*i +: 2] == CELL_EMPTY) begin
        low = 4'(i);
        has_empty = 1'b1;
      end
    end
  end
  assign turn = enable && who == WHO_RUN && has_empty && n1 == n2 + 4'd1;
`ifdef TTT_AUTO_STRATEGY_EN
  logic [11:0] line;
  logic        lw, lb, wf, wf_d, bf, bf_d;
  logic [3:0]  li, wi, wi_d, bi, bi_d;
  assign line = LINE_TABLE[cnt[2:0]];
  ttt_line_eval u_eval (
    .a(board[{line[11:8], 1'b0} +: 2]),
    .b(board[{line[7:4], 1'b0} +: 2]),
    .c(board[{line[3:0], 1'b0} +: 2]),
    .ia(line[11:8]),
    .ib(line[7:4]),
    .ic(line[3:0]),
    .win(lw),
    .block(lb),
    .idx(li)
  );
  // On the final scan cycle the live line result still counts if nothing was recorded earlier.
  assign choice = (wf || lw) ? (wf ? wi : li) :
                  (bf || lb) ? (bf ? bi : li) :
                  board[9:8] == CELL_EMPTY ? 4'd4 : low;
  assign last = cnt[2:0] == 3'd7;
`else
  assign choice = low;
  assign last = 1'b1;
`endif
  // The board may have moved on during THINK, so the pick is re-validated on exit.
  assign ok = board[{choice, 1'b0} +: 2] == CELL_EMPTY;
  assign ack = board[{position, 1'b0} +: 2] != CELL_EMPTY;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    position_d = position;
    play_d = 1'b0;
    err_d = 1'b0;
`ifdef TTT_AUTO_STRATEGY_EN
    wf_d = wf;
    wi_d = wi;
    bf_d = bf;
    bi_d = bi;
`endif
    if (!enable || who != WHO_RUN) state_d = IDLE;
    else case (state)
      IDLE: if (turn) begin
        state_d = THINK;
        cnt_d = '0;
`ifdef TTT_AUTO_STRATEGY_EN
        wf_d = 1'b0;
        bf_d = 1'b0;
`endif
      end
      THINK: begin
`ifdef TTT_AUTO_STRATEGY_EN
        if (lw && !wf) begin
          wf_d = 1'b1;
          wi_d = li;
        end
        if (lb && !bf) begin
          bf_d = 1'b1;
          bi_d = li;
        end
`endif
        if (last) begin
          state_d = ok ? DRIVE : IDLE;
          cnt_d = '0;
          position_d = ok ? choice : position;
        end else cnt_d = cnt + 16'd1;
      end
      // play follows DRIVE entry by one edge and stays up for PLAY_HOLD cycles.
      DRIVE: if (cnt == PH) begin
        state_d = WAIT;
        cnt_d = '0;
      end else begin
        play_d = 1'b1;
        cnt_d = cnt + 16'd1;
      end
      default: if (ack) state_d = IDLE;
      else if (cnt == AT) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else cnt_d = cnt + 16'd1;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      position <= '0;
      play <= 1'b0;
      err <= 1'b0;
`ifdef TTT_AUTO_STRATEGY_EN
      wf <= 1'b0;
      wi <= '0;
      bf <= 1'b0;
      bi <= '0;
`endif
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      position <= position_d;
      play <= play_d;
      err <= err_d;
`ifdef TTT_AUTO_STRATEGY_EN
      wf <= wf_d;
      wi <= wi_d;
      bf <= bf_d;
      bi <= bi_d;
`endif
    end
  end
endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// tb_tic_tac_toe_auto_player: directed self-checking bench for the auto player.
module tb_tic_tac_toe_auto_player;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
`ifdef TTT_AUTO_STRATEGY_EN
  localparam int LAT = 9;
  localparam int A_POS = 4;
  localparam int B_POS = 8;
  localparam int C_POS = 5;
`else
  localparam int LAT = 2;
  localparam int A_POS = 1;
  localparam int B_POS = 2;
  localparam int C_POS = 2;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;
  logic play, busy, err;
  logic [3:0] position;
  int n_cmp = 0;
  int n_err = 0;
  int e;
  logic [17:0] bd;
  always #5 clock = ~clock;
  tic_tac_toe_auto_player #(.PLAY_HOLD(5), .ACK_TIMEOUT(32)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .who(who),
    .play(play), .position(position), .busy(busy), .err(err)
  );
  function automatic logic [17:0] mk(input int i, input logic [1:0] v);
    mk = 18'(v) << (2 * i);
  endfunction
  task automatic set_board(input logic [17:0] b);
    {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = b;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_play(output int n);
    n = 0;
    while (!play && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic count_high(output int n);
    n = 0;
    while (play && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask
  initial begin
    who = 2'b00;
    set_board('0);
    enable = 1'b1;
    tick();
    tick();
    check("rst_play", play, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", position, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    tick();
    check("empty_idle", busy, 0);
    // Single player1 mark at cell 0: centre (strategy) or cell 1 (plain).
    set_board(mk(0, P1));
    tick();
    check("a_busy", busy, 1);
    wait_play(e);
    check("a_latency", e, LAT);
    check("a_pos", position, A_POS);
    count_high(e);
    check("a_hold", e, 5);
    check("a_wait_busy", busy, 1);
    set_board(mk(0, P1) | mk(A_POS, P2));
    tick();
    check("a_ack_idle", busy, 0);
    check("a_no_err", err, 0);
    // Asynchronous reset while play is high.
    set_board(mk(0, P1));
    tick();
    wait_play(e);
    check("r_latency", e, LAT);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("r_play", play, 0);
    check("r_busy", busy, 0);
    check("r_pos", position, 0);
    enable = 1'b0;
    set_board('0);
    tick();
    reset = 1'b1;
    tick();
    enable = 1'b1;
    // Block: P1 at 0,4 and P2 at 1 -> diagonal 0,4,8.
    bd = mk(0, P1) | mk(4, P1) | mk(1, P2);
    set_board(bd);
    tick();
    wait_play(e);
    check("b_latency", e, LAT);
    check("b_pos", position, B_POS);
    set_board(bd | mk(B_POS, P2));
    wait_idle(e);
    check("b_done", busy, 0);
    check("b_no_err", err, 0);
    // Win at 5 preferred over block at 2.
    bd = mk(0, P1) | mk(1, P1) | mk(6, P1) | mk(3, P2) | mk(4, P2);
    set_board(bd);
    tick();
    wait_play(e);
    check("c_latency", e, LAT);
    check("c_pos", position, C_POS);
    set_board(bd | mk(C_POS, P2));
    wait_idle(e);
    check("c_done", busy, 0);
    // Acknowledge timeout: err 37 edges after play rises, then retrigger.
    set_board(mk(0, P1));
    tick();
    wait_play(e);
    e = 0;
    while (!err && e < 100) begin
      tick();
      e++;
    end
    check("d_err_time", e, 37);
    check("d_err_idle", busy, 0);
    tick();
    check("d_err_pulse", err, 0);
    check("d_retrigger", busy, 1);
    wait_play(e);
    check("d_latency", e, LAT);
    check("d_pos", position, A_POS);
    // Game result during DRIVE forces IDLE.
    who = P1;
    tick();
    check("f_play", play, 0);
    check("f_busy", busy, 0);
    // Game result during THINK: no move ever issued.
    who = 2'b00;
    tick();
    check("e_busy", busy, 1);
    who = P1;
    tick();
    check("e_idle", busy, 0);
    e = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (play) e++;
    end
    check("e_no_play", e, 0);
    // Disabled player stays idle.
    who = 2'b00;
    enable = 1'b0;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) e++;
    end
    check("g_disabled", e, 0);
    // Full board never leaves IDLE.
    enable = 1'b1;
    set_board(mk(0, P1) | mk(1, P2) | mk(2, P1) | mk(3, P1) | mk(4, P2) |
              mk(5, P2) | mk(6, P2) | mk(7, P1) | mk(8, P1));
    e = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) e++;
    end
    check("h_full", e, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tic_tac_toe_auto_player.md
TIC_TAC_TOE_AUTO_PLAYER -- requirements
Module: tic_tac_toe_auto_player

Interface
REQ-001 SHALL have parameter PLAY_HOLD, default 5: number of cycles `play` is held high per move.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 32: number of cycles to wait for the chosen cell to fill after `play` drops.
REQ-003 SHALL have port clock, input, 1: single clock; all flops on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: auto player permitted to move.
REQ-006 SHALL have ports pos1..pos9, input, 2 each: board cells 0..8 (00 empty, 01 player1, 10 player2).
REQ-007 SHALL have port who, input, 2: game result (00 running, 01 player1 won, 10 player2 won, 11 draw).
REQ-008 SHALL have port play, output, 1: move strobe to the game.
REQ-009 SHALL have port position, output, 4: chosen cell, 0..8.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port err, output, 1: one-cycle pulse on acknowledge timeout.

Function
REQ-012 SHALL act as player2; turn condition: count(01) == count(10)+1, who==00, enable==1, at least one empty cell.
REQ-013 SHALL implement states IDLE, THINK, DRIVE and WAIT.
REQ-014 IDLE SHALL go to THINK on the edge where the turn condition is sampled true (edge k).
REQ-015 THINK SHALL evaluate one line per cycle over 8 cycles, in this order: rows (0,1,2)(3,4,5)(6,7,8), cols (0,3,6)(1,4,7)(2,5,8), diags (0,4,8)(2,4,6).
REQ-016 A win cell SHALL be the empty cell of a line holding two 10; a block cell SHALL be the empty cell of a line holding two 01; the first of each found in line order SHALL be recorded.
REQ-017 Choice priority SHALL be win > block > cell 4 if empty > lowest-index empty cell.
REQ-018 THINK SHALL register the choice into position and enter DRIVE; play SHALL be high from edge k+9 for exactly PLAY_HOLD cycles.
REQ-019 position SHALL remain stable from DRIVE entry until the next THINK completes.
REQ-020 DRIVE SHALL go to WAIT when PLAY_HOLD expires; WAIT SHALL return to IDLE on the first cycle the chosen cell reads nonzero.
REQ-021 If WAIT lasts ACK_TIMEOUT cycles, err SHALL pulse for 1 cycle and the block SHALL return to IDLE; retrigger follows the normal turn condition.
REQ-022 who != 00 or enable == 0 in any state SHALL force IDLE on the next edge, with play low from that edge.
REQ-023 A board that changes during THINK SHALL NOT restart the scan; the chosen cell SHALL be rechecked empty at THINK exit, and IDLE entered (no play) if it is occupied.
REQ-024 A full board SHALL never leave IDLE.

Reset
REQ-025 reset low SHALL immediately set state=IDLE, play=0, position=0, busy=0, err=0, and clear all counters, even mid-DRIVE.
REQ-026 Deassertion SHALL take effect at the next rising clock edge; no move SHALL be issued before the turn condition is sampled true.

Configuration
REQ-027 Macro TTT_AUTO_STRATEGY_EN defined: behaviour SHALL be as in REQ-015..REQ-018.
REQ-028 Macro TTT_AUTO_STRATEGY_EN undefined: THINK SHALL last 1 cycle, choose the lowest-index empty cell, and play SHALL rise at edge k+2; the line-scan logic SHALL be absent.

Structure
REQ-029 Package ttt_pkg SHALL hold the cell codes, who codes, the 8-entry line table (3 x 4-bit indices each) and the state enum.
REQ-030 Sub-module ttt_line_eval SHALL take 3 cells plus indices and return win, block and the empty-cell index; it is instantiated once and time-shared across THINK cycles.

Verification
REQ-031 reset low mid-DRIVE -> play=0, busy=0, position=0 immediately.
REQ-032 pos1=01, others 00, macro on -> play high 5 cycles from k+9, position=4; then pos5=10 -> IDLE, busy=0. Macro off -> position=1, play from k+2.
REQ-033 P1 at 0,4 and P2 at 1 -> block, position=8.
REQ-034 P1 at 0,1,6 and P2 at 3,4 -> win preferred over block at 2, position=5.
REQ-035 Board never updated after move -> err pulse exactly PLAY_HOLD+ACK_TIMEOUT cycles after play rises, then IDLE and retrigger.
REQ-036 who=01 asserted during THINK -> IDLE next edge, play never asserted.
